// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants and clear-FSM state type for the register file
package reg_file_pkg;

  localparam int WIDTH          = 32;
  localparam int ADDR_WIDTH     = 5;
  localparam int NUM_REGS       = 2 ** ADDR_WIDTH;
  localparam int WR_COUNT_WIDTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - read/write/clear bus between the datapath and the register file
interface reg_file_if #(
  parameter int WIDTH      = reg_file_pkg::WIDTH,
  parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH
) ();
  import reg_file_pkg::*;

  logic [ADDR_WIDTH-1:0]     rs1_addr;
  logic [ADDR_WIDTH-1:0]     rs2_addr;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic [WIDTH-1:0]          rd_data;
  logic                      reg_write;
  logic                      clr_start;
  logic [ADDR_WIDTH-1:0]     dbg_addr;
  logic [WIDTH-1:0]          rs1_data;
  logic [WIDTH-1:0]          rs2_data;
  logic [WIDTH-1:0]          dbg_data;
  logic                      busy;
  logic [WR_COUNT_WIDTH-1:0] wr_count;

  modport master (
    output rs1_addr, rs2_addr, rd_addr, rd_data, reg_write, clr_start, dbg_addr,
    input  rs1_data, rs2_data, dbg_data, busy, wr_count
  );

  modport slave (
    input  rs1_addr, rs2_addr, rd_addr, rd_data, reg_write, clr_start, dbg_addr,
    output rs1_data, rs2_data, dbg_data, busy, wr_count
  );

endinterface

// File: rtl/reg_file_clr_ctrl.sv
// rtl/reg_file_clr_ctrl.sv - sequential clear FSM, walks the index from x1 to x31
module reg_file_clr_ctrl
  import reg_file_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_start,
  output logic                  busy,
  output logic                  clr_en,
  output logic [ADDR_WIDTH-1:0] clr_idx
);

  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = '1;

  clr_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] idx, idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // clr_start is only looked at in IDLE, so a pulse during a clear is dropped
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    clr_en    = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt = CLEAR;
          idx_nxt   = FIRST_IDX;
        end
      end
      CLEAR: begin
        clr_en  = 1'b1;
        idx_nxt = idx + 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy    = (state == CLEAR);
  assign clr_idx = idx;

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2R1W register file with x0 hardwired to zero, sequential clear and write counter
module reg_file #(
  parameter int WIDTH      = reg_file_pkg::WIDTH,
  parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  reg_file_if.slave  bus
);
  import reg_file_pkg::*;

  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0]          regs [NREGS];
  logic [WR_COUNT_WIDTH-1:0] wr_count;
  logic                      busy;
  logic                      clr_en;
  logic [ADDR_WIDTH-1:0]     clr_idx;
  logic                      wr_en;

  reg_file_clr_ctrl u_clr_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_start (bus.clr_start),
    .busy      (busy),
    .clr_en    (clr_en),
    .clr_idx   (clr_idx)
  );

  // busy gates writes, so the clear and a write never target the array together
  assign wr_en = bus.reg_write && (bus.rd_addr != '0) && !busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (clr_en) begin
      regs[clr_idx] <= '0;
    end else if (wr_en) begin
      regs[bus.rd_addr] <= bus.rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
    end else if (wr_en && (wr_count != '1)) begin
      wr_count <= wr_count + 1'b1;
    end
  end

  // no write-to-read bypass: the ALU loop stays broken by the array flops
  assign bus.rs1_data = (bus.rs1_addr == '0) ? '0 : regs[bus.rs1_addr];
  assign bus.rs2_data = (bus.rs2_addr == '0) ? '0 : regs[bus.rs2_addr];
  assign bus.dbg_data = (bus.dbg_addr == '0) ? '0 : regs[bus.dbg_addr];
  assign bus.busy     = busy;
  assign bus.wr_count = wr_count;

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard bench for reg_file
module tb_reg_file;
  import reg_file_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_file_if bus ();

  reg_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  localparam int S_RS1  = 0;
  localparam int S_RS2  = 1;
  localparam int S_DBG  = 2;
  localparam int S_BUSY = 3;
  localparam int S_CNT  = 4;
  localparam int S_SUM  = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  logic [31:0] mon_a;
  int          pass_cnt  = 0;
  int          total_cnt = 0;

  task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_RS1:   return bus.rs1_data;
      S_RS2:   return bus.rs2_data;
      S_DBG:   return bus.dbg_data;
      S_BUSY:  return 32'(bus.busy);
      S_CNT:   return 32'(bus.wr_count);
      S_SUM:   return bus.rs1_data + bus.rs2_data;
      default: return 'x;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      mon_a = actual(mon_e.sel);
      total_cnt++;
      if (mon_a === mon_e.exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", mon_e.name, mon_a, mon_e.exp);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [31:0] data);
    bus.reg_write = 1'b1;
    bus.rd_addr   = 5'(addr);
    bus.rd_data   = data;
    cyc();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.rs1_addr  = '0;
    bus.rs2_addr  = '0;
    bus.rd_addr   = '0;
    bus.rd_data   = '0;
    bus.reg_write = 1'b0;
    bus.clr_start = 1'b0;
    bus.dbg_addr  = '0;
    cyc();
    cyc();
    bus.rs1_addr = 5'd5;
    bus.dbg_addr = 5'd31;
    expect_val("reset_busy", S_BUSY, 32'd0);
    expect_val("reset_cnt", S_CNT, 32'd0);
    expect_val("reset_rs1", S_RS1, 32'd0);
    expect_val("reset_dbg", S_DBG, 32'd0);
    cyc();

    // first edge after release must already take the write
    rst_n = 1'b1;
    wr(5, 32'd15);
    wr(6, 32'd10);
    bus.reg_write = 1'b0;
    bus.rs1_addr  = 5'd5;
    bus.rs2_addr  = 5'd6;
    expect_val("basic_rs1", S_RS1, 32'd15);
    expect_val("basic_rs2", S_RS2, 32'd10);
    expect_val("basic_sum", S_SUM, 32'd25);
    expect_val("basic_cnt", S_CNT, 32'd2);
    cyc();

    wr(0, 32'hDEADBEEF);
    bus.reg_write = 1'b0;
    bus.rs1_addr  = 5'd0;
    bus.dbg_addr  = 5'd0;
    expect_val("x0_rs1", S_RS1, 32'd0);
    expect_val("x0_dbg", S_DBG, 32'd0);
    expect_val("x0_cnt", S_CNT, 32'd2);
    cyc();

    bus.rs1_addr = 5'd7;
    expect_val("same_cycle_old", S_RS1, 32'd0);
    wr(7, 32'h7FFFFFFF);
    bus.reg_write = 1'b0;
    expect_val("same_cycle_new", S_RS1, 32'h7FFFFFFF);
    expect_val("same_cycle_cnt", S_CNT, 32'd3);
    cyc();

    for (int i = 1; i < 32; i++) wr(i, 32'(i));
    bus.reg_write = 1'b0;
    bus.rs1_addr  = 5'd3;
    bus.rs2_addr  = 5'd31;
    expect_val("fill_rs1", S_RS1, 32'd3);
    expect_val("fill_rs2", S_RS2, 32'd31);
    expect_val("fill_cnt", S_CNT, 32'd34);
    // clr_start together with a valid write: write lands, clear wipes it later
    bus.clr_start = 1'b1;
    expect_val("clr_start_idle_busy", S_BUSY, 32'd0);
    wr(2, 32'd200);
    bus.clr_start = 1'b0;
    bus.reg_write = 1'b0;
    for (int c = 1; c <= 31; c++) begin
      if (c == 2) begin
        bus.dbg_addr = 5'd2;
        expect_val("clr_joint_write", S_DBG, 32'd200);
      end
      if (c == 10) begin
        bus.reg_write = 1'b1;
        bus.rd_addr   = 5'd3;
        bus.rd_data   = 32'd99;
        bus.rs1_addr  = 5'd9;
        bus.rs2_addr  = 5'd20;
        bus.dbg_addr  = 5'd10;
        expect_val("clr_live_cleared", S_RS1, 32'd0);
        expect_val("clr_live_kept", S_RS2, 32'd20);
        expect_val("clr_live_current", S_DBG, 32'd10);
      end
      if (c == 20) bus.clr_start = 1'b1;
      expect_val("clr_busy", S_BUSY, 32'd1);
      cyc();
      bus.reg_write = 1'b0;
      bus.clr_start = 1'b0;
    end
    expect_val("clr_done_busy", S_BUSY, 32'd0);
    expect_val("clr_done_cnt", S_CNT, 32'd35);
    for (int i = 0; i < 32; i++) begin
      bus.dbg_addr = 5'(i);
      expect_val("clr_done_reg", S_DBG, 32'd0);
      cyc();
    end

    wr(30, 32'd300);
    bus.reg_write = 1'b0;
    bus.clr_start = 1'b1;
    cyc();
    bus.clr_start = 1'b0;
    repeat (11) cyc();
    expect_val("midclr_busy_before", S_BUSY, 32'd1);
    cyc();
    rst_n        = 1'b0;
    bus.dbg_addr = 5'd30;
    expect_val("midclr_rst_busy", S_BUSY, 32'd0);
    expect_val("midclr_rst_cnt", S_CNT, 32'd0);
    expect_val("midclr_rst_x30", S_DBG, 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    expect_val("midclr_idle", S_BUSY, 32'd0);
    cyc();
    for (int i = 1; i < 32; i++) begin
      bus.dbg_addr = 5'(i);
      expect_val("midclr_reg", S_DBG, 32'd0);
      cyc();
    end
    expect_val("midclr_still_idle", S_BUSY, 32'd0);
    wr(8, 32'd8);
    bus.reg_write = 1'b0;
    bus.rs1_addr  = 5'd8;
    expect_val("post_rst_write", S_RS1, 32'd8);
    expect_val("post_rst_cnt", S_CNT, 32'd1);
    cyc();

    for (int n = 0; n < 65533; n++) wr((n % 31) + 1, 32'(n));
    bus.reg_write = 1'b0;
    expect_val("sat_edge", S_CNT, 32'h0000FFFE);
    cyc();
    for (int n = 0; n < 7; n++) wr(n + 1, 32'(n));
    bus.reg_write = 1'b0;
    expect_val("sat_full", S_CNT, 32'h0000FFFF);
    cyc();
    wr(9, 32'd1);
    bus.reg_write = 1'b0;
    expect_val("sat_hold", S_CNT, 32'h0000FFFF);
    cyc();

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      total_cnt++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH, 32, data width of each register and of every data port, equal to the ALU WIDTH.
REQ-002 Parameter ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH = 32.
REQ-003 Clock and reset SHALL be: one clock, clk, rising edge; reset is asynchronous and active-low, rst_n.
REQ-004 clk  input  1  sole clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 rs1_addr  input  ADDR_WIDTH  read port 1 index, feeds ALU A.
REQ-007 rs2_addr  input  ADDR_WIDTH  read port 2 index, feeds ALU B.
REQ-008 rd_addr  input  ADDR_WIDTH  write index.
REQ-009 rd_data  input  WIDTH  write data, normally the ALU result.
REQ-010 reg_write  input  1  write request for this cycle.
REQ-011 clr_start  input  1  one-cycle pulse that starts a sequential clear of x1..x31.
REQ-012 dbg_addr  input  ADDR_WIDTH  debug read index.
REQ-013 rs1_data / rs2_data / dbg_data  output  WIDTH each  combinational read data.
REQ-014 busy  output  1  high while the clear sequence runs.
REQ-015 wr_count  output  16  count of committed writes.

Function
REQ-016 Reads SHALL be combinational from the array; an index of 0 SHALL return 0 on every read port.
REQ-017 Reads SHALL return pre-edge contents. A same-cycle write to the read index SHALL NOT be bypassed, so no combinational path exists through the ALU.
REQ-018 A write SHALL commit on the rising clk edge when reg_write=1, rd_addr!=0 and busy=0. It SHALL be visible on reads from the next cycle.
REQ-019 Writes with rd_addr=0 SHALL be discarded and SHALL NOT increment wr_count.
REQ-020 FSM states SHALL be IDLE and CLEAR.
- IDLE->CLEAR on clr_start=1: index loads 1 and busy is registered high.
- CLEAR->IDLE on the edge that zeroes index 31.
REQ-021 In CLEAR, each edge SHALL zero reg[index] and increment index. busy SHALL be high for exactly 31 cycles.
REQ-022 In CLEAR, reg_write SHALL be ignored (no commit, no count), and clr_start SHALL be ignored.
REQ-023 If clr_start and a valid write arrive together in IDLE, the write SHALL commit, and the clear SHALL later zero that register.
REQ-024 During CLEAR, reads SHALL show live contents: already-cleared registers read 0, uncleared registers keep their prior values.
REQ-025 wr_count SHALL increment by 1 per committed write and saturate at 16'hFFFF.

Reset
REQ-026 rst_n=0 SHALL asynchronously set all 31 registers, wr_count and index to 0, the state to IDLE, and busy to 0, including mid-clear.
REQ-027 After rst_n deasserts, the first write SHALL be accepted on the first rising edge.

Structure
REQ-028 A shared package SHALL hold WIDTH, ADDR_WIDTH, NUM_REGS, the FSM state typedef (IDLE, CLEAR) and WR_COUNT_WIDTH=16.
REQ-029 The clear FSM and index counter SHALL be one sub-module, reg_file_clr_ctrl. It outputs busy, the clear index and a clear-enable; the array and read muxes stay in reg_file.

Verification
REQ-030 Basic write/read: write x5=15 and x6=10, then rs1=5, rs2=6, ALU_ctr=000 -> rs1_data=15, rs2_data=10, ALU result=25, wr_count=2.
REQ-031 x0: write x0=32'hDEADBEEF, then rs1=0 -> rs1_data=0, wr_count unchanged.
REQ-032 Same-cycle read of a write target: write x7=32'h7FFFFFFF with rs1=7 -> old value 0 in that cycle, 32'h7FFFFFFF next cycle.
REQ-033 Clear with blocked write: fill x1..x31 with their index, pulse clr_start, then write x3=99 at cycle 10 -> busy high for 31 cycles, write ignored, all reads 0 afterwards.
REQ-034 Reset mid-clear: assert rst_n=0 at clear cycle 12 -> busy=0, state IDLE, wr_count=0, all registers read 0.
REQ-035 Saturation: force 65540 committed writes -> wr_count=16'hFFFF.
